// File: rtl/sdram_read_arbiter.sv
// Purpose : round-robin arbiter sharing one SDRAM block-read port between I-cache and D-cache.
// Latency : grant/address one cycle after request; each word appears at its owner one cycle after MemDataReady.
// Backpr. : none; a granted burst always runs to BLOCK_WORDS words, and later requests wait in IDLE.
// Ports   : I*/D* request/address in, grant/data/ready/last out per cache port;
//           MemRead* request/address out and MemData* in towards the SDRAM controller;
//           ProtocolError is a sticky flag for data arriving outside a burst.
module sdram_read_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 IReadRequest,
  input  logic [31:0]          IReadAddress,
  output logic                 IGrant,
  output logic [WORD_SIZE-1:0] IDataOut,
  output logic                 IDataReady,
  output logic                 IDataLast,
  input  logic                 DReadRequest,
  input  logic [31:0]          DReadAddress,
  output logic                 DGrant,
  output logic [WORD_SIZE-1:0] DDataOut,
  output logic                 DDataReady,
  output logic                 DDataLast,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [WORD_SIZE-1:0] MemDataIn,
  input  logic                 MemDataReady,
  output logic                 ProtocolError
);

  localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_WORDS - 1);
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

  state_t               state, state_next;
  logic                 owner;
  logic                 last_owner;
  logic [CW-1:0]        count;
  logic [WORD_SIZE-1:0] data;
  logic                 ready_pulse;
  logic                 last_pulse;
  logic                 take;
  logic                 grant_sel;
  logic                 word;
  logic                 last_word;

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    grant_sel  = PORT_I;
    word       = (state == BURST) && MemDataReady;
    last_word  = word && (count == LAST_CNT);
    case (state)
      IDLE: begin
        if (IReadRequest || DReadRequest) begin
          take       = 1'b1;
          state_next = BURST;
          // On a tie the port that did not win last time goes next.
          if (IReadRequest && DReadRequest) grant_sel = ~last_owner;
          else                              grant_sel = DReadRequest ? PORT_D : PORT_I;
        end
      end
      BURST:   if (last_word) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      owner          <= PORT_I;
      last_owner     <= PORT_D;
      count          <= '0;
      data           <= '0;
      ready_pulse    <= 1'b0;
      last_pulse     <= 1'b0;
      MemReadAddress <= '0;
      ProtocolError  <= 1'b0;
    end else begin
      ready_pulse <= word;
      last_pulse  <= last_word;
      if (take) begin
        owner          <= grant_sel;
        last_owner     <= grant_sel;
        MemReadAddress <= (grant_sel == PORT_D) ? DReadAddress : IReadAddress;
        count          <= '0;
      end
      if (word) begin
        data  <= MemDataIn;
        count <= count + 1'b1;
      end
      // Data outside a burst has no owner: drop it and flag it until reset.
      if (MemDataReady && (state != BURST)) ProtocolError <= 1'b1;
    end
  end

  // Owner is unchanged through BURST and RELEASE, so the final word's pulse
  // (which lands in RELEASE) still routes to the right port under grant.
  assign MemReadRequest = (state == BURST);
  assign IGrant         = (state != IDLE) && (owner == PORT_I);
  assign DGrant         = (state != IDLE) && (owner == PORT_D);
  assign IDataOut       = (owner == PORT_I) ? data : '0;
  assign DDataOut       = (owner == PORT_D) ? data : '0;
  assign IDataReady     = ready_pulse && (owner == PORT_I);
  assign DDataReady     = ready_pulse && (owner == PORT_D);
  assign IDataLast      = last_pulse && (owner == PORT_I);
  assign DDataLast      = last_pulse && (owner == PORT_D);

endmodule

// File: doc/sdram_read_arbiter.md
# sdram_read_arbiter

Two-port read arbiter that shares the single SDRAM-controller block-read interface between the instruction cache (I-port) and the data cache (D-port). Each port issues a block-fill request. The arbiter grants one port at a time using round-robin priority, then forwards that port's address to the SDRAM controller. It counts the returned burst of BLOCK_WORDS words, routes each word back to the owning port, and releases the interface before the next grant.

## Interface
Parameters:
- BLOCK_WORDS, 4: words per burst; power of two, ≥2
- WORD_SIZE, 32: data width of every data bus

Ports:
- Clk  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-low reset
- IReadRequest  in  1  I-port block-fill request (level)
- IReadAddress  in  32  I-port miss address
- IGrant  out  1  I-port owns the SDRAM interface
- IDataOut  out  WORD_SIZE  returned word for I-port
- IDataReady  out  1  IDataOut valid, one-cycle pulse per word
- IDataLast  out  1  marks the final word of the I-port burst
- DReadRequest, DReadAddress, DGrant, DDataOut, DDataReady, DDataLast: D-port equivalents, same widths and meanings
- MemReadAddress  out  32  address presented to the SDRAM controller
- MemReadRequest  out  1  burst request to the SDRAM controller
- MemDataIn  in  WORD_SIZE  burst data from the SDRAM controller
- MemDataReady  in  1  MemDataIn valid this cycle
- ProtocolError  out  1  sticky flag: MemDataReady seen outside BURST

## Operation
- States: IDLE, BURST, RELEASE.
- IDLE, no requests: stay in IDLE; MemReadRequest=0; both grants 0.
- IDLE, exactly one request: grant that port.
- IDLE, both requests: grant the port not in last_owner.
- last_owner is a 1-bit register; reset value = D, so the I-port wins the first tie.
- On grant: latch the requester's address into MemReadAddress unmodified; set owner and last_owner; clear word counter; go to BURST.
- BURST:
  - MemReadRequest=1; owner's Grant=1.
  - Each edge with MemDataReady=1: register MemDataIn into owner's DataOut; pulse owner's DataReady; increment counter (width log2(BLOCK_WORDS)).
  - Word with counter==BLOCK_WORDS-1: also pulse DataLast, clear MemReadRequest, go to RELEASE.
- RELEASE: one cycle. Requests ignored. Owner's Grant stays 1 so the last word is delivered under grant. Then go to IDLE; both grants drop.
- Non-owner outputs: DataOut=0, DataReady=0, DataLast=0 at all times.
- Owner drops its request mid-burst: the burst still runs to completion and data is still forwarded. The arbiter never aborts a burst because the SDRAM controller cannot cancel one.
- Requester address changes mid-burst: ignored; the latched value is used.
- Request still high in the first IDLE cycle after RELEASE: treated as a new request and arbitrated normally. Requesters must drop the request on the DataLast cycle unless they want another fill.
- MemDataReady=1 in IDLE or RELEASE: data is discarded and ProtocolError is set. ProtocolError clears only on reset.
- Reset low at any edge: state←IDLE, counter←0, last_owner←D. An in-flight burst is abandoned and requesters must reissue.

## Timing
- Reset values: every output 0, including MemReadAddress, MemReadRequest, both Grants, all DataOut/DataReady/DataLast, and ProtocolError.
- Request latency: request sampled high in IDLE at edge t → MemReadRequest=1, Grant=1 and MemReadAddress valid after edge t.
- Data latency: MemDataReady high at edge t → owner's DataReady=1 during cycle t+1 for exactly one cycle; DataOut holds that word until the next word arrives or reset.
- Last word at edge t → MemReadRequest=0 from t; Grant=0 from t+1; earliest next MemReadRequest=1 from t+2. MemReadRequest is therefore low for at least 2 cycles between bursts.
- Exactly BLOCK_WORDS DataReady pulses per grant; DataLast coincides with the final pulse.
- Back-to-back contention with both requests held: grants strictly alternate I, D, I, D, …

## Test plan
- Single I request, addr 0x0000_1040, memory returns 4 words A0..A3 one per cycle → MemReadAddress=0x0000_1040 one cycle after request; IDataReady pulses 4×; IDataLast on A3; DGrant never 1.
- Both ports request in the same cycle after reset (I 0x100, D 0x2000) → I served first; D granted; D's MemReadRequest rises exactly 2 cycles after I's MemReadRequest falls; both ports get all 4 words.
- Memory delivers words with gaps (MemDataReady 1,0,0,1,0,1,1) → exactly 4 DataReady pulses; counter advances only on ready cycles; no early release.
- D drops DReadRequest after word 1 → burst completes; DDataReady pulses 4×; then IDLE with no new grant.
- Reset driven low mid-burst after 2 words → next cycle all outputs 0 and state IDLE; re-request is granted to I on a tie.
- MemDataReady pulsed in IDLE → ProtocolError=1 and stays 1; no DataReady on either port; cleared only by Reset=0.
